// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Also used by the planned transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int OVERSAMPLE    = 16;
    localparam int HALF_BIT      = 7;
    localparam int DATA_BITS_DEF = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every bdiv+1 clocks.
// A synchronous clear re-phases the tick to an external event.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic [DIV_WIDTH-1:0] i_bdiv,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = (r_cnt == i_bdiv);

    // Count 0..bdiv and wrap; >= keeps a shrunk divisor from running away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt >= i_bdiv) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a programmable divisor.
// Writes each good byte straight into the downstream receive fifo.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] bdiv,
    input  logic                 fifo_full,
    input  logic                 clr_err,
    output logic                 wr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [3:0] SAMP_HALF = 4'(HALF_BIT);
    localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [3:0]           r_samp;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_wr;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_ferr;
    logic                 r_ovr;

    logic w_rxs;
    logic w_tick;
    logic w_start;

    assign w_rxs   = r_sync2;
    assign w_start = (r_state == IDLE) && !w_rxs;

    assign wr        = r_wr;
    assign dout      = r_dout;
    assign busy      = (r_state != IDLE);
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    uart_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_start),
        .i_bdiv(bdiv),
        .o_tick(w_tick)
    );

    // Frame FSM; a new error event overrides a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_samp  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_wr    <= 1'b0;
            r_dout  <= '0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (clr_err) begin
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_samp  <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_samp == SAMP_HALF) begin
                            if (!w_rxs) begin
                                r_state <= DATA;
                                r_idx   <= '0;
                                r_samp  <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_samp <= r_samp + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_samp <= r_samp + 1'b1;
                        if (r_samp == SAMP_LAST) begin
                            r_shift[r_idx] <= w_rxs;
                            if (r_idx == IDX_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_samp <= r_samp + 1'b1;
                        if (r_samp == SAMP_LAST) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                                if (fifo_full) begin
                                    r_ovr <= 1'b1;
                                end else begin
                                    r_wr   <= 1'b1;
                                    r_dout <= r_shift;
                                end
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= BREAK;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames in, fifo writes checked.
// Expected bytes are queued by the stimulus and popped by a monitor.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] bdiv = 16'd0;
    logic        fifo_full = 1'b0;
    logic        clr_err = 1'b0;
    logic        wr;
    logic [7:0]  dout;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    uart_rx #(
        .DIV_WIDTH(16),
        .DATA_BITS(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .bdiv     (bdiv),
        .fifo_full(fifo_full),
        .clr_err  (clr_err),
        .wr       (wr),
        .dout     (dout),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int t_fall = 0;
    bit lat_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] e_mon;
    bit model_ovr = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every fifo write must match the oldest expected byte.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr actual=%02h required=no_write",
                         dout);
            end else begin
                e_mon = exp_q.pop_front();
                chk("wr_data", {24'd0, dout}, {24'd0, e_mon});
                last_good = e_mon;
                if (lat_en) begin
                    lat_en = 1'b0;
                    checks++;
                    if ((cyc - t_fall) < 150 || (cyc - t_fall) > 156) begin
                        errors++;
                        $display("FAIL wr_latency actual=%0d required=150..156",
                                 cyc - t_fall);
                    end
                end
            end
        end
    end

    task automatic bit_time();
        repeat (16 * (int'(bdiv) + 1)) @(negedge clk);
    endtask

    // Drive one 8N1 frame LSB first; entered and left on a negedge.
    task automatic send(input logic [7:0] d, input logic stopb);
        rxd = 1'b0;
        t_fall = cyc;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            bit_time();
        end
        rxd = stopb;
        bit_time();
    endtask

    // Frame cut short by reset in the middle of data bit ab.
    task automatic send_abort(input logic [7:0] d, input int ab);
        rxd = 1'b0;
        bit_time();
        for (int i = 0; i < ab; i++) begin
            rxd = d[i];
            bit_time();
        end
        rxd = d[ab];
        repeat (8 * (int'(bdiv) + 1)) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_wr", {31'd0, wr}, 32'd0);
        chk("abort_dout", {24'd0, dout}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_flags", {30'd0, frame_err, overrun}, 32'd0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int wc;
        logic [7:0] d;
        bit full;

        repeat (3) @(negedge clk);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal byte at the fastest divisor
        bdiv = 16'd0;
        exp_q.push_back(8'hA5);
        lat_en = 1'b1;
        send(8'hA5, 1'b1);
        wait_idle(40, "nom_idle");
        repeat (4) @(negedge clk);
        chk("nom_count", wr_count, 32'd1);
        chk("nom_dout", {24'd0, dout}, 32'h A5);
        chk("nom_flags", {30'd0, frame_err, overrun}, 32'd0);

        // Back-to-back frames, divisor 3
        bdiv = 16'd3;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        wait_idle(200, "b2b_idle");
        repeat (4) @(negedge clk);
        chk("b2b_count", wr_count, 32'd4);
        chk("b2b_flags", {30'd0, frame_err, overrun}, 32'd0);

        // Short low glitch must be rejected
        bdiv = 16'd0;
        wc = wr_count;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        wait_idle(12, "glitch_idle");
        repeat (40) @(negedge clk);
        chk("glitch_count", wr_count, wc);
        chk("glitch_flags", {30'd0, frame_err, overrun}, 32'd0);

        // Bad stop bit followed by a long break
        send(8'h55, 1'b0);
        repeat (40) bit_time();
        chk("ferr_set", {31'd0, frame_err}, 32'd1);
        chk("ferr_break", {31'd0, busy}, 32'd1);
        chk("ferr_count", wr_count, wc);
        rxd = 1'b1;
        wait_idle(8, "ferr_idle");
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ferr_clr", {31'd0, frame_err}, 32'd0);

        // Overrun: byte dropped while fifo full
        fifo_full = 1'b1;
        send(8'h12, 1'b1);
        wait_idle(40, "ovr_idle");
        fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_dout", {24'd0, dout}, {24'd0, last_good});
        chk("ovr_count", wr_count, wc);
        exp_q.push_back(8'h34);
        send(8'h34, 1'b1);
        wait_idle(40, "ovr2_idle");
        repeat (4) @(negedge clk);
        chk("ovr2_dout", {24'd0, dout}, 32'h34);
        chk("ovr2_sticky", {31'd0, overrun}, 32'd1);

        // Reset during data bit 4, then a clean frame
        wc = wr_count;
        send_abort(8'h81, 4);
        repeat (300) @(negedge clk);
        chk("abort_nowr", wr_count, wc);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        wait_idle(40, "post_idle");
        repeat (4) @(negedge clk);
        chk("post_dout", {24'd0, dout}, 32'h7E);
        chk("post_flags", {30'd0, frame_err, overrun}, 32'd0);

        // Randomized frames with random divisor, gaps and fifo_full
        model_ovr = 1'b0;
        for (int k = 0; k < 24; k++) begin
            bdiv = 16'($urandom_range(0, 3));
            full = ($urandom_range(0, 4) == 0);
            fifo_full = full;
            d = 8'($urandom);
            if (full) model_ovr = 1'b1;
            else exp_q.push_back(d);
            send(d, 1'b1);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle(200, "rand_idle");
        fifo_full = 1'b0;
        repeat (8) @(negedge clk);
        chk("rand_ovr", {31'd0, overrun}, {31'd0, model_ovr});
        chk("rand_ferr", {31'd0, frame_err}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
